// File: rtl/pattern_pkg.sv
// Shared types and helpers for the 7-phase one-hot pattern generator and its
// burst controller.
package pattern_pkg;

  typedef enum logic [6:0] {
    S0 = 7'b0000001,
    S1 = 7'b0000010,
    S2 = 7'b0000100,
    S3 = 7'b0001000,
    S4 = 7'b0010000,
    S5 = 7'b0100000,
    S6 = 7'b1000000
  } phase_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_t;

  function automatic logic is_onehot(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

  // Ring order S0->S4->S6->S3->S5->S2->S1->S0; anything else recovers to S0.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      S0:      return S4;
      S4:      return S6;
      S6:      return S3;
      S3:      return S5;
      S5:      return S2;
      S2:      return S1;
      S1:      return S0;
      default: return S0;
    endcase
  endfunction

  function automatic logic pattern_bit(input phase_t p);
    case (p)
      S0, S4, S3: return 1'b1;
      S6, S5, S2, S1: return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pattern_phase_gen.sv
// One-hot phase register with beat-driven advance, idle resync and
// illegal-state recovery to S0.
module pattern_phase_gen
  import pattern_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic       resync,
  output logic [6:0] phase,
  output logic       out_bit,
  output logic       illegal
);

  logic [6:0] state;
  logic [6:0] state_nxt;

  // Next phase: corruption recovery takes priority over resync and advance.
  always_comb begin
    illegal   = !is_onehot(state);
    state_nxt = state;
    if (illegal) begin
      state_nxt = S0;
    end else if (resync) begin
      state_nxt = S0;
    end else if (advance) begin
      state_nxt = next_phase(phase_t'(state));
    end else begin
      state_nxt = state;
    end
  end

  // Output bit is decoded straight from the phase register.
  always_comb begin
    if (illegal) begin
      out_bit = 1'b0;
    end else begin
      out_bit = pattern_bit(phase_t'(state));
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S0;
    end else begin
      state <= state_nxt;
    end
  end

  assign phase = state;

endmodule

// File: rtl/pattern_burst_ctrl.sv
// Burst controller: accepts a start/len command and streams one pattern bit
// per accepted valid/ready beat, with abort, completion pulse and error flag.
module pattern_burst_ctrl
  import pattern_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             resync,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_bit,
  output logic [6:0]       phase,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctrl_t            ctrl;
  ctrl_t            ctrl_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             beat;
  logic             start_acc;
  logic             resync_go;
  logic             illegal;

  assign beat = out_valid & out_ready;
  assign busy = (ctrl != IDLE);

  pattern_phase_gen u_gen (
    .clk     (clk),
    .reset   (reset),
    .advance (beat),
    .resync  (resync_go),
    .phase   (phase),
    .out_bit (out_bit),
    .illegal (illegal)
  );

  // Controller next-state and counter update; start wins over resync in IDLE.
  always_comb begin
    ctrl_nxt  = ctrl;
    cnt_nxt   = cnt;
    start_acc = 1'b0;
    resync_go = 1'b0;
    case (ctrl)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          if (len != '0) begin
            cnt_nxt  = len;
            ctrl_nxt = RUN;
          end else begin
            ctrl_nxt = DONE;
          end
        end else if (resync) begin
          resync_go = 1'b1;
        end else begin
          resync_go = 1'b0;
        end
      end
      RUN: begin
        if (beat) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          cnt_nxt = cnt;
        end
        // A beat coinciding with abort still counts; the consumer took it.
        if (abort || (beat && (cnt == CNT_ONE))) begin
          ctrl_nxt = DONE;
        end else begin
          ctrl_nxt = RUN;
        end
      end
      DONE: begin
        ctrl_nxt = IDLE;
      end
      default: begin
        ctrl_nxt = IDLE;
        cnt_nxt  = '0;
      end
    endcase
  end

  // Controller registers; valid/done are registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl      <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ctrl      <= ctrl_nxt;
      cnt       <= cnt_nxt;
      out_valid <= (ctrl_nxt == RUN);
      done      <= (ctrl_nxt == DONE);
      err       <= illegal | (err & ~start_acc);
    end
  end

endmodule

// File: tb/tb_pattern_burst_ctrl.sv
// Scoreboard bench for pattern_burst_ctrl: expected pattern bits are queued
// when a burst is started and popped on every accepted beat.
module tb_pattern_burst_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] len;
  logic       abort;
  logic       resync;
  logic       out_ready;
  logic       out_valid;
  logic       out_bit;
  logic [6:0] phase;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  int mpos = 0;
  bit track = 1'b1;
  int beats = 0;
  int step_no = 0;
  int last_beat_step = -1;
  int done_step = -1;
  int done_cnt = 0;

  always #5 clk = ~clk;

  pattern_burst_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .resync    (resync),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .phase     (phase),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  function automatic logic [6:0] ring_ph(input int p);
    case (p)
      0: return 7'b0000001;
      1: return 7'b0010000;
      2: return 7'b1000000;
      3: return 7'b0001000;
      4: return 7'b0100000;
      5: return 7'b0000100;
      6: return 7'b0000010;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic bit ring_bit(input int p);
    case (p)
      0, 1, 3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Called just after a negedge with inputs driven; samples, then waits one cycle.
  task automatic step();
    bit b;
    #1;
    step_no++;
    b = out_valid && out_ready;
    if (track) check("phase", phase, ring_ph(mpos));
    if (track && out_valid) check("out_bit", out_bit, ring_bit(mpos));
    if (done) begin
      done_cnt++;
      done_step = step_no;
      check("valid_in_done", out_valid, 0);
    end
    if (b) begin
      if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
      else check("beat_bit", out_bit, exp_q.pop_front());
      beats++;
      last_beat_step = step_no;
    end
    @(negedge clk);
    if (b) mpos = (mpos + 1) % 7;
  endtask

  // rmode 0: always ready; 1: ready pattern 1,0,0,1,0,0...
  task automatic burst(input int l, input int rmode, input int abort_at, input int exp_beats);
    int guard;
    int start_step;
    exp_q.delete();
    for (int k = 0; k < l; k++) exp_q.push_back(ring_bit((mpos + k) % 7));
    beats = 0; done_cnt = 0; done_step = -1; last_beat_step = -1;
    start = 1'b1; len = 8'(l);
    step();
    start = 1'b0; resync = 1'b0;
    start_step = step_no;
    guard = 0;
    while (done_cnt == 0 && guard < 100) begin
      out_ready = (rmode == 0) ? 1'b1 : ((guard % 3) == 0);
      abort = (abort_at > 0) && (beats == abort_at - 1) && out_ready && out_valid;
      step();
      abort = 1'b0;
      guard++;
    end
    check("done_seen", done_cnt, 1);
    check("beat_count", beats, exp_beats);
    if (exp_beats > 0) check("done_latency", done_step, last_beat_step + 1);
    else check("done_latency", done_step, start_step + 1);
    #1;
    check("idle_busy", busy, 0);
    check("done_one_cycle", done, 0);
    check("idle_valid", out_valid, 0);
    @(negedge clk);
    out_ready = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; len = 8'd0; abort = 1'b0; resync = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_phase", phase, 7'b0000001);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    reset = 1'b1;
    @(negedge clk);

    burst(7, 0, 0, 7);
    check("wrap_phase", phase, 7'b0000001);
    burst(3, 0, 0, 3);
    check("after3_phase", phase, 7'b0001000);
    burst(4, 0, 0, 4);
    burst(10, 0, 3, 3);
    check("abort_phase", phase, 7'b0001000);
    burst(5, 1, 0, 5);
    burst(0, 0, 0, 0);
    burst(2, 0, 0, 2);

    resync = 1'b1;
    step();
    resync = 1'b0;
    mpos = 0;
    check("resync_phase", phase, 7'b0000001);

    // Leave the ring off S0, then start together with resync: start must win.
    burst(2, 0, 0, 2);
    resync = 1'b1;
    burst(2, 0, 0, 2);

    // Asynchronous reset in the middle of a burst.
    start = 1'b1; len = 8'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_phase", phase, 7'b0000001);
    @(negedge clk);
    check("midrst_done", done, 0);
    reset = 1'b1;
    mpos = 0;
    @(negedge clk);

    // Corrupt the phase register.
    track = 1'b0;
    force dut.u_gen.state = 7'b0000011;
    #1;
    check("illegal_bit", out_bit, 0);
    @(posedge clk);
    #1;
    release dut.u_gen.state;
    @(negedge clk);
    check("illegal_err", err, 1);
    @(negedge clk);
    check("illegal_recover", phase, 7'b0000001);
    mpos = 0;
    track = 1'b1;
    repeat (3) step();
    check("err_sticky", err, 1);
    burst(1, 0, 0, 1);
    check("err_cleared", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
